// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and default widths for the I2C memory arbiter
package i2c_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} arb_state_t;
  typedef enum logic       {OWN_HOST, OWN_I2C}      owner_t;

endpackage

// File: rtl/i2c_mem_req_slot.sv
// rtl/i2c_mem_req_slot.sv - per-requester request slot: pend flag, captured command,
// overflow flag, read-data and ack registers
module i2c_mem_req_slot
  import i2c_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_done,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_pend,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_overflow
);

  logic              r_pend;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_overflow;

  // A request landing in the completing cycle is accepted; the old r_we is still
  // what decides whether this completion captures read data.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pend     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ack <= i_done;
      if (i_req && (!r_pend || i_done)) begin
        r_pend  <= 1'b1;
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end else if (i_req) begin
        r_overflow <= 1'b1;
      end else if (i_done) begin
        r_pend <= 1'b0;
      end
      if (i_done && !r_we) begin
        r_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_pend     = r_pend;
  assign o_we       = r_we;
  assign o_addr     = r_addr;
  assign o_wdata    = r_wdata;
  assign o_ack      = r_ack;
  assign o_rdata    = r_rdata;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/i2c_mem_arbiter.sv
// rtl/i2c_mem_arbiter.sv - three-state grant sequencer sharing one register memory
// between the I2C engine and the local host port
module i2c_mem_arbiter
  import i2c_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int I2C_PRIO = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_i2c_req,
  input  logic              i_i2c_we,
  input  logic [ADDR_W-1:0] i_i2c_addr,
  input  logic [DATA_W-1:0] i_i2c_wdata,
  output logic              o_i2c_ack,
  output logic [DATA_W-1:0] o_i2c_rdata,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_ack,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_hold_clock_low,
  output logic [1:0]        o_req_overflow
);

  arb_state_t        r_state;
  owner_t            r_owner;
  owner_t            r_last_owner;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_i2c_pend, w_host_pend;
  logic              w_i2c_we, w_host_we;
  logic [ADDR_W-1:0] w_i2c_addr, w_host_addr;
  logic [DATA_W-1:0] w_i2c_wdata, w_host_wdata;
  logic              w_i2c_ovf, w_host_ovf;
  logic              w_i2c_done, w_host_done;
  owner_t            w_sel;

  assign w_i2c_done  = (r_state == CAPTURE) && (r_owner == OWN_I2C);
  assign w_host_done = (r_state == CAPTURE) && (r_owner == OWN_HOST);

  i2c_mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_i2c_slot (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_i2c_req),
    .i_we        (i_i2c_we),
    .i_addr      (i_i2c_addr),
    .i_wdata     (i_i2c_wdata),
    .i_done      (w_i2c_done),
    .i_mem_rdata (i_mem_rdata),
    .o_pend      (w_i2c_pend),
    .o_we        (w_i2c_we),
    .o_addr      (w_i2c_addr),
    .o_wdata     (w_i2c_wdata),
    .o_ack       (o_i2c_ack),
    .o_rdata     (o_i2c_rdata),
    .o_overflow  (w_i2c_ovf)
  );

  i2c_mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_host_slot (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_host_req),
    .i_we        (i_host_we),
    .i_addr      (i_host_addr),
    .i_wdata     (i_host_wdata),
    .i_done      (w_host_done),
    .i_mem_rdata (i_mem_rdata),
    .o_pend      (w_host_pend),
    .o_we        (w_host_we),
    .o_addr      (w_host_addr),
    .o_wdata     (w_host_wdata),
    .o_ack       (o_host_ack),
    .o_rdata     (o_host_rdata),
    .o_overflow  (w_host_ovf)
  );

  always_comb begin
    w_sel = OWN_HOST;
    if (w_i2c_pend && w_host_pend) begin
      if (I2C_PRIO != 0) w_sel = OWN_I2C;
      else               w_sel = (r_last_owner == OWN_I2C) ? OWN_HOST : OWN_I2C;
    end else if (w_i2c_pend) begin
      w_sel = OWN_I2C;
    end
  end

  // Memory outputs are loaded on entry to ACCESS and cleared on leaving it, so they
  // depend only on registered slot contents, never on the raw request inputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= IDLE;
      r_owner      <= OWN_HOST;
      r_last_owner <= OWN_HOST;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_i2c_pend || w_host_pend) begin
            r_state     <= ACCESS;
            r_owner     <= w_sel;
            r_mem_en    <= 1'b1;
            r_mem_we    <= (w_sel == OWN_I2C) ? w_i2c_we    : w_host_we;
            r_mem_addr  <= (w_sel == OWN_I2C) ? w_i2c_addr  : w_host_addr;
            r_mem_wdata <= (w_sel == OWN_I2C) ? w_i2c_wdata : w_host_wdata;
          end
        end
        ACCESS: begin
          r_state     <= CAPTURE;
          r_mem_en    <= 1'b0;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
        end
        CAPTURE: begin
          r_state      <= IDLE;
          r_last_owner <= r_owner;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mem_en         = r_mem_en;
  assign o_mem_we         = r_mem_we;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_wdata      = r_mem_wdata;
  // Stretch is forced low while reset is held so every output reads 0 in reset.
  assign o_hold_clock_low = i_rst & (i_i2c_req | w_i2c_pend);
  assign o_req_overflow   = {w_i2c_ovf, w_host_ovf};

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// tb/tb_i2c_mem_arbiter.sv - scoreboard bench for i2c_mem_arbiter (priority and round-robin builds)
module tb_i2c_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       i2c_req, i2c_we, host_req, host_we;
  logic [6:0] i2c_addr, host_addr;
  logic [7:0] i2c_wdata, host_wdata;

  logic       i2c_ack_a, host_ack_a, mem_en_a, mem_we_a, hold_a;
  logic [7:0] i2c_rdata_a, host_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [6:0] mem_addr_a;
  logic [1:0] ovf_a;
  logic       i2c_ack_b, host_ack_b, mem_en_b, mem_we_b, hold_b;
  logic [7:0] i2c_rdata_b, host_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [6:0] mem_addr_b;
  logic [1:0] ovf_b;

  logic [7:0] mem_a [128];
  logic [7:0] mem_b [128];
  logic [7:0] ref_mem [128];

  typedef struct packed { logic rd; logic [7:0] data; } exp_t;
  exp_t q_i2c[$];
  exp_t q_host[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_en, cnt_ack;

  always #5 clk = ~clk;

  i2c_mem_arbiter #(.I2C_PRIO(1)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_i2c_req(i2c_req), .i_i2c_we(i2c_we), .i_i2c_addr(i2c_addr), .i_i2c_wdata(i2c_wdata),
    .o_i2c_ack(i2c_ack_a), .o_i2c_rdata(i2c_rdata_a),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_ack(host_ack_a), .o_host_rdata(host_rdata_a),
    .o_mem_en(mem_en_a), .o_mem_we(mem_we_a), .o_mem_addr(mem_addr_a), .o_mem_wdata(mem_wdata_a),
    .i_mem_rdata(mem_rdata_a), .o_hold_clock_low(hold_a), .o_req_overflow(ovf_a)
  );

  i2c_mem_arbiter #(.I2C_PRIO(0)) u_dut_rr (
    .i_clk(clk), .i_rst(rst),
    .i_i2c_req(i2c_req), .i_i2c_we(i2c_we), .i_i2c_addr(i2c_addr), .i_i2c_wdata(i2c_wdata),
    .o_i2c_ack(i2c_ack_b), .o_i2c_rdata(i2c_rdata_b),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_ack(host_ack_b), .o_host_rdata(host_rdata_b),
    .o_mem_en(mem_en_b), .o_mem_we(mem_we_b), .o_mem_addr(mem_addr_b), .o_mem_wdata(mem_wdata_b),
    .i_mem_rdata(mem_rdata_b), .o_hold_clock_low(hold_b), .o_req_overflow(ovf_b)
  );

  always @(posedge clk) begin
    if (mem_en_a) begin
      if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
      mem_rdata_a <= mem_a[mem_addr_a];
    end
    if (mem_en_b) begin
      if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
      mem_rdata_b <= mem_b[mem_addr_b];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] last_i2c_rd, last_host_rd;
  exp_t       e_i2c, e_host;

  always @(negedge clk) begin
    if (!rst) begin
      last_i2c_rd  = 8'h00;
      last_host_rd = 8'h00;
    end
    if (i2c_ack_a) begin
      if (q_i2c.size() == 0) check("i2c_ack_unexpected", 32'd1, 32'd0);
      else begin
        e_i2c = q_i2c.pop_front();
        if (e_i2c.rd) last_i2c_rd = e_i2c.data;
        check("i2c_rdata", {24'd0, i2c_rdata_a}, {24'd0, last_i2c_rd});
      end
    end
    if (host_ack_a) begin
      if (q_host.size() == 0) check("host_ack_unexpected", 32'd1, 32'd0);
      else begin
        e_host = q_host.pop_front();
        if (e_host.rd) last_host_rd = e_host.data;
        check("host_rdata", {24'd0, host_rdata_a}, {24'd0, last_host_rd});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i2c_req = 0; i2c_we = 0; i2c_addr = '0; i2c_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic drive_i2c(input logic we, input logic [6:0] a, input logic [7:0] d, input bit accept);
    exp_t e;
    i2c_req = 1; i2c_we = we; i2c_addr = a; i2c_wdata = d;
    if (accept) begin
      e.rd = !we;
      e.data = ref_mem[a];
      if (we) ref_mem[a] = d;
      q_i2c.push_back(e);
    end
  endtask

  task automatic drive_host(input logic we, input logic [6:0] a, input logic [7:0] d, input bit accept);
    exp_t e;
    host_req = 1; host_we = we; host_addr = a; host_wdata = d;
    if (accept) begin
      e.rd = !we;
      e.data = ref_mem[a];
      if (we) ref_mem[a] = d;
      q_host.push_back(e);
    end
  endtask

  initial begin
    rst = 0;
    idle_inputs();

    // reset held with both requesters pulsing
    for (int c = 0; c < 3; c++) begin
      step(); idle_inputs();
      i2c_req = (c != 1); host_req = (c != 1);
      @(negedge clk);
      check("rst_mem", {15'd0, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a}, 32'd0);
      check("rst_rsp", {11'd0, i2c_ack_a, host_ack_a, i2c_rdata_a, host_rdata_a, hold_a, ovf_a}, 32'd0);
    end
    for (int c = 0; c < 3; c++) begin
      step(); idle_inputs(); rst = 1;
      @(negedge clk);
      check("post_rst_en", {31'd0, mem_en_a}, 32'd0);
    end

    // I2C write
    for (int c = 0; c < 6; c++) begin
      step(); idle_inputs();
      if (c == 0) drive_i2c(1'b1, 7'h2C, 8'hCD, 1);
      @(negedge clk);
      check("wr_hold", {31'd0, hold_a}, {31'd0, c <= 3});
      check("wr_en", {31'd0, mem_en_a}, {31'd0, c == 2});
      check("wr_bus", {15'd0, mem_we_a, mem_addr_a, mem_wdata_a}, (c == 2) ? {15'd0, 1'b1, 7'h2C, 8'hCD} : 32'd0);
      check("wr_ack", {31'd0, i2c_ack_a}, {31'd0, c == 4});
    end

    // host read of the freshly written location
    for (int c = 0; c < 7; c++) begin
      step(); idle_inputs();
      if (c == 0) drive_host(1'b0, 7'h2C, 8'h00, 1);
      @(negedge clk);
      check("rd_ack", {31'd0, host_ack_a}, {31'd0, c == 4});
      check("rd_hold", {31'd0, hold_a}, 32'd0);
      if (c >= 4) check("rd_held", {24'd0, host_rdata_a}, 32'hCD);
    end

    // contention
    for (int c = 0; c < 9; c++) begin
      step(); idle_inputs();
      if (c == 0) begin
        drive_i2c(1'b1, 7'h40, 8'h11, 1);
        drive_host(1'b0, 7'h2C, 8'h00, 1);
      end
      @(negedge clk);
      check("ct_en", {31'd0, mem_en_a}, {31'd0, c == 2 || c == 5});
      if (c == 2) check("ct_addr_i2c", {25'd0, mem_addr_a}, 32'h40);
      if (c == 5) check("ct_addr_host", {25'd0, mem_addr_a}, 32'h2C);
      check("ct_i2c_ack", {31'd0, i2c_ack_a}, {31'd0, c == 4});
      check("ct_host_ack", {31'd0, host_ack_a}, {31'd0, c == 7});
      check("ct_rr_i2c_ack", {31'd0, i2c_ack_b}, {31'd0, c == 4});
    end

    // I2C request in its own CAPTURE cycle is accepted and chains
    for (int c = 0; c < 9; c++) begin
      step(); idle_inputs();
      if (c == 0) drive_i2c(1'b1, 7'h50, 8'hA1, 1);
      if (c == 3) drive_i2c(1'b0, 7'h50, 8'h00, 1);
      @(negedge clk);
      check("b2b_ack", {31'd0, i2c_ack_a}, {31'd0, c == 4 || c == 7});
      check("b2b_hold", {31'd0, hold_a}, {31'd0, c <= 6});
      check("b2b_en", {31'd0, mem_en_a}, {31'd0, c == 2 || c == 5});
    end
    check("b2b_no_ovf", {30'd0, ovf_a}, 32'd0);

    // host overflow
    cnt_en = 0; cnt_ack = 0;
    for (int c = 0; c < 10; c++) begin
      step(); idle_inputs();
      if (c == 0) drive_host(1'b1, 7'h10, 8'h77, 1);
      if (c == 2) drive_host(1'b1, 7'h10, 8'h99, 0);
      @(negedge clk);
      cnt_en += int'(mem_en_a);
      cnt_ack += int'(host_ack_a);
      check("ovf_flag", {30'd0, ovf_a}, (c >= 3) ? 32'd1 : 32'd0);
    end
    check("ovf_accesses", cnt_en, 1);
    check("ovf_acks", cnt_ack, 1);
    check("ovf_rr_flag", {30'd0, ovf_b}, 32'd1);

    // round-robin build: make I2C the last owner, then contend
    for (int c = 0; c < 6; c++) begin
      step(); idle_inputs();
      if (c == 0) drive_i2c(1'b0, 7'h2C, 8'h00, 1);
      @(negedge clk);
    end
    for (int c = 0; c < 10; c++) begin
      step(); idle_inputs();
      if (c == 0) begin
        drive_i2c(1'b0, 7'h10, 8'h00, 1);
        drive_host(1'b1, 7'h20, 8'h3C, 1);
      end
      @(negedge clk);
      check("rr_host_ack", {31'd0, host_ack_b}, {31'd0, c == 4});
      check("rr_i2c_ack", {31'd0, i2c_ack_b}, {31'd0, c == 7});
      if (c == 2) check("rr_addr", {25'd0, mem_addr_b}, 32'h20);
      if (c == 7) check("rr_i2c_rdata", {24'd0, i2c_rdata_b}, 32'h77);
      check("pr_i2c_ack", {31'd0, i2c_ack_a}, {31'd0, c == 4});
      check("pr_host_ack", {31'd0, host_ack_a}, {31'd0, c == 7});
    end
    check("ovf_sticky", {30'd0, ovf_a}, 32'd1);

    // reset while the access is in ACCESS
    for (int c = 0; c < 8; c++) begin
      step(); idle_inputs();
      rst = (c != 2);
      if (c == 0) drive_i2c(1'b0, 7'h2C, 8'h00, 0);
      @(negedge clk);
      if (c == 2) check("ra_en_access", {31'd0, mem_en_a}, 32'd1);
      if (c >= 3) begin
        check("ra_en", {31'd0, mem_en_a}, 32'd0);
        check("ra_ack", {31'd0, i2c_ack_a}, 32'd0);
        check("ra_hold", {31'd0, hold_a}, 32'd0);
        check("ra_ovf", {30'd0, ovf_a}, 32'd0);
      end
      if (c == 3) check("ra_rdata", {24'd0, i2c_rdata_a}, 32'd0);
    end

    check("sb_i2c_empty", q_i2c.size(), 0);
    check("sb_host_empty", q_host.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_mem_arbiter.md
Name: i2c_mem_arbiter

Overview:
- Arbitrates the subordinate's single-port register memory (128 x 8) between two requesters:
  - the I2C protocol engine, which serves bus reads and writes;
  - a local host port.
- Sequences every memory access as a fixed three-state grant, so only one requester can drive the memory at a time.
- Drives hold_clock_low to stretch SCL while an I2C access is waiting for, or occupying, the memory.
- Sits between the I2C engine inside i2c_top and the memory macro.

Parameters:
- ADDR_W, 7, memory address width (the 7-bit memory address sent after the device address).
- DATA_W, 8, data width.
- I2C_PRIO, 1, 1 = I2C always wins a conflict; 0 = round-robin on last_owner.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- i2c_req  in  1  single-cycle request pulse from the I2C engine.
- i2c_we  in  1  write enable, sampled with i2c_req.
- i2c_addr  in  ADDR_W  address, sampled with i2c_req.
- i2c_wdata  in  DATA_W  write data, sampled with i2c_req.
- i2c_ack  out  1  one-cycle completion pulse.
- i2c_rdata  out  DATA_W  read data; valid on i2c_ack, held until the next I2C read completes.
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  same rules as the I2C side.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_W  same rules as i2c_rdata.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; synchronous read, valid the cycle after mem_en.
- hold_clock_low  out  1  SCL stretch request to the I2C engine.
- req_overflow  out  2  sticky error flags: [1] I2C, [0] host.

Behaviour:
- Reset (rst low at a clk edge):
  - state = IDLE, both pending flags = 0, last_owner = HOST.
  - All outputs = 0, including rdata registers and req_overflow.
  - Reset mid-access: no ack is issued, the access is dropped, and mem_en is 0 from the next cycle.
- Request capture:
  - A req pulse latches {we, addr, wdata} into that requester's slot and sets its pend flag on the next edge.
  - If req arrives while pend = 1 and the same requester's ack is not in that cycle: the request is dropped and the corresponding req_overflow bit sets (sticky until reset).
  - If req arrives in the same cycle as that requester's ack: it is accepted, and pend remains 1.
- FSM states: IDLE -> ACCESS -> CAPTURE -> IDLE.
  - IDLE: no memory activity. If any pend flag is set, select the owner and go to ACCESS.
    - Only one pending: that requester is the owner.
    - Both pending, I2C_PRIO = 1: I2C.
    - Both pending, I2C_PRIO = 0: the requester that is not last_owner.
  - ACCESS: mem_en = 1; mem_we, mem_addr and mem_wdata come from the owner's slot. Next state is CAPTURE.
  - CAPTURE:
    - On a read, mem_rdata is registered into the owner's rdata at the edge.
    - On a write, rdata is unchanged.
    - At the same edge: the owner's ack register is set, its pend flag clears (unless a new req arrives that cycle), last_owner is updated, and the next state is IDLE.
- Ack: a registered pulse lasting exactly one cycle, coincident with the first IDLE cycle after CAPTURE.
- Timing:
  - Request pulse at cycle 0 -> pend at 1 -> ACCESS at 2 -> CAPTURE at 3 -> ack at 4.
  - Minimum grant spacing is 3 cycles; a new grant can be made in the ack cycle.
- hold_clock_low:
  - Equals i2c_req | i2c_pend, combinationally.
  - It is high from the I2C request cycle through the cycle before i2c_ack, and low in the i2c_ack cycle unless a new i2c_req is present.
- Idle outputs: mem_we, mem_addr and mem_wdata are 0 whenever mem_en = 0.
- No combinational path from any req input to mem_* outputs.

Decomposition:
- Shared package i2c_pkg:
  - ADDR_W and DATA_W defaults;
  - enum arb_state_t {IDLE, ACCESS, CAPTURE};
  - enum owner_t {OWN_HOST, OWN_I2C}.
- Sub-module i2c_mem_req_slot, instantiated once per requester. It contains:
  - the pend flag;
  - the {we, addr, wdata} capture register;
  - overflow detection;
  - the rdata register;
  - the ack register.
- The top level holds the FSM, the owner/last_owner registers and the memory mux.

Test Plan:
- Reset: hold rst low 3 cycles with both reqs pulsing -> all outputs 0; no mem_en for 2 cycles after rst rises.
- I2C write: i2c_req = 1, we = 1, addr = 0x2C, wdata = 0xCD at cycle 0 -> mem_en = mem_we = 1 with addr 0x2C and wdata 0xCD at cycle 2; i2c_ack at 4; hold_clock_low high in cycles 0-3 and low at 4.
- Host read: host_req, we = 0, addr = 0x2C after the write -> host_ack 4 cycles later with host_rdata = 0xCD, held afterwards.
- Contention, I2C_PRIO = 1: both req at cycle 0 -> I2C mem_en at 2, i2c_ack at 4; host mem_en at 5, host_ack at 7.
- Contention, I2C_PRIO = 0 with last_owner = I2C: both req at cycle 0 -> host is served first.
- Overflow: host_req at cycle 0 and again at cycle 2 -> req_overflow = 2'b01 (sticky); exactly one memory access; one host_ack.
- Reset in ACCESS: rst low during cycle 2 -> no ack ever, pend = 0, mem_en = 0 from cycle 3, hold_clock_low = 0.
